// File: rtl/chain_counter_pkg.sv
// Shared types and constants for the chain_counter block.
package chain_counter_pkg;

  // Run sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Chain semantics selected by the MODE parameter.
  localparam int MODE_PIPE  = 0;
  localparam int MODE_CHAIN = 1;

  // tick_cnt must hold every value 0..RUN_CYCLES, and for free-run (0) it
  // still needs at least one bit to saturate in.
  function automatic int tick_cnt_width(input int run_cycles);
    return $clog2(run_cycles + 2);
  endfunction

endpackage

// File: rtl/chain_stage.sv
// One counter stage: a WIDTH-bit register that either loads a preset or
// adds STEP to whatever value the parent routes into its adder.
module chain_stage #(
  parameter int WIDTH = 4,
  parameter int STEP  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] add_in_i,
  output logic [WIDTH-1:0] d_o,
  output logic [WIDTH-1:0] q_o
);

  // STEP is truncated to the stage width; the add wraps modulo 2^WIDTH,
  // which matches a WIDTH+1 bit sum with the carry dropped.
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_w;

  // Next value: load wins over tick, otherwise hold.
  always_comb begin
    d_w = q_q;
    if (load_i) begin
      d_w = load_val_i;
    end else if (tick_i) begin
      d_w = add_in_i + STEP_W;
    end
  end

  // Stage register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= d_w;
    end
  end

  assign d_o = d_w;
  assign q_o = q_q;

endmodule

// File: rtl/chain_counter.sv
// Multi-stage counter chain with a bounded run sequencer.
//
// Handshake: start/load are only looked at in IDLE, stop/en only in RUN;
// there is no backpressure, every control input is a level sampled on the
// rising edge.  busy/done/wrap are registered and change only on edges.
module chain_counter
  import chain_counter_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int STAGES     = 2,
  parameter int MODE       = 0,
  parameter int STEP       = 1,
  parameter int RUN_CYCLES = 5
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  stop,
  input  logic                                  en,
  input  logic                                  load,
  input  logic [WIDTH-1:0]                      load_val,
  output logic [STAGES*WIDTH-1:0]               stage_q,
  output logic [tick_cnt_width(RUN_CYCLES)-1:0] tick_cnt,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  wrap,
  output logic [1:0]                            state_dbg
);

  localparam int              TW       = tick_cnt_width(RUN_CYCLES);
  localparam logic [TW-1:0]   RUN_LAST = TW'(RUN_CYCLES);
  localparam logic [TW-1:0]   CNT_ONE  = TW'(1);
  localparam logic [TW-1:0]   CNT_MAX  = '1;

  state_e          state_q;
  logic            busy_q;
  logic            done_q;
  logic            wrap_q;
  logic [TW-1:0]   tick_cnt_q;
  logic            load_w;
  logic            tick_w;
  logic            wrap_w;
  logic [WIDTH-1:0] unused_fwd_w;

  assign load_w = (state_q == IDLE) && load;
  assign tick_w = (state_q == RUN) && en && !stop;

  // Each stage forwards either its registered value (pipelined) or its
  // next value (chained) to the following stage's adder.  Stage 0 adds
  // to itself.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] d_w;
    logic [WIDTH-1:0] add_w;
    logic [WIDTH-1:0] fwd_w;

    assign fwd_w = (MODE == MODE_CHAIN) ? d_w : q_w;

    if (k == 0) begin : g_head
      assign add_w = q_w;
    end else begin : g_link
      assign add_w = g_stage[k-1].fwd_w;
    end

    chain_stage #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_stage (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .load_i     (load_w),
      .load_val_i (load_val),
      .tick_i     (tick_w),
      .add_in_i   (add_w),
      .d_o        (d_w),
      .q_o        (q_w)
    );

    assign stage_q[k*WIDTH +: WIDTH] = q_w;
  end

  // The last stage's forward value has no consumer.
  assign unused_fwd_w = g_stage[STAGES-1].fwd_w;

  // Stage 0 carried out of WIDTH bits exactly when its ticked value came
  // out smaller than the old one (STEP is below 2^WIDTH after truncation).
  assign wrap_w = tick_w && (g_stage[0].d_w < g_stage[0].q_w);

  // Run sequencer with registered busy/done/wrap and the tick counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      wrap_q <= wrap_w;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (!load && start) begin
            state_q    <= RUN;
            busy_q     <= 1'b1;
            tick_cnt_q <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (en) begin
            if (RUN_CYCLES == 0) begin
              if (tick_cnt_q != CNT_MAX) begin
                tick_cnt_q <= tick_cnt_q + CNT_ONE;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + CNT_ONE;
              if (tick_cnt_q + CNT_ONE == RUN_LAST) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tick_cnt  = tick_cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wrap      = wrap_q;
  assign state_dbg = state_q;

endmodule
